// File: rtl/seg_txt_shifter.sv
// seg_txt_shifter: captures a 64-bit segment pattern and shifts it LSB-first
// over a 3-wire chain (seg_clk / seg_sout / SEG_PEN), then pulses the latch.
// Optional build macro SEG_AUTO_REFRESH_EN: self-restart after REFRESH_GAP idle cycles.
module seg_txt_shifter #(
  parameter int CLK_DIV     = 2,
  parameter int REFRESH_GAP = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] SEG_TXT,
  output logic        busy,
  output logic        done,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        SEG_PEN,
  output logic        seg_clrn
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // Out-of-range parameters are rejected at elaboration.
  if (CLK_DIV < 1 || CLK_DIV > 255 || REFRESH_GAP < 1) begin : g_param_check
    $error("seg_txt_shifter: CLK_DIV must be 1..255 and REFRESH_GAP >= 1");
  end

  state_t      state_q;
  logic [63:0] shadow_q;
  logic [5:0]  bit_q;
  logic [7:0]  div_q;
  logic [7:0]  div_d;
  logic        div_last;
  logic        phase_q;      // 0: seg_clk low half, 1: seg_clk high half
  logic        busy_q;
  logic        done_q;
  logic        seg_clk_q;
  logic        seg_sout_q;
  logic        seg_pen_q;
  logic        seg_clrn_q;
  logic        go;           // frame launch request seen in IDLE

  // Shared half-period divider: wraps to 0 after CLK_DIV cycles.
  always_comb begin
    div_last = (div_q == DIV_LAST);
    div_d    = div_last ? 8'd0 : div_q + 8'd1;
  end

`ifdef SEG_AUTO_REFRESH_EN
  localparam int            GW       = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(REFRESH_GAP - 1);

  logic [GW-1:0] gap_q;
  logic          armed_q;    // set once a frame has completed since reset

  always_comb begin
    go = start || (armed_q && (gap_q == '0));
  end

  // Idle-gap counter: loaded at frame end (and on any launch), counts down in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q   <= '0;
      armed_q <= 1'b0;
    end else if (state_q == DONE) begin
      gap_q   <= GAP_LOAD;
      armed_q <= 1'b1;
    end else if (state_q == IDLE) begin
      if (go) begin
        gap_q <= GAP_LOAD;
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end
`else
  always_comb begin
    go = start;
  end
`endif

  // Frame sequencer with all chain outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seg_clk_q  <= 1'b0;
      seg_sout_q <= 1'b0;
      seg_pen_q  <= 1'b0;
      seg_clrn_q <= 1'b0;
    end else begin
      // Chain clear is only asserted during reset.
      seg_clrn_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_q    <= SHIFT;
            shadow_q   <= SEG_TXT;
            bit_q      <= '0;
            div_q      <= '0;
            phase_q    <= 1'b0;
            busy_q     <= 1'b1;
            seg_clk_q  <= 1'b0;
            seg_sout_q <= SEG_TXT[0];
          end
        end
        SHIFT: begin
          div_q <= div_d;
          if (div_last) begin
            if (!phase_q) begin
              phase_q   <= 1'b1;
              seg_clk_q <= 1'b1;
            end else begin
              // Falling edge: advance to the next bit.
              phase_q    <= 1'b0;
              seg_clk_q  <= 1'b0;
              shadow_q   <= {1'b0, shadow_q[63:1]};
              seg_sout_q <= shadow_q[1];
              bit_q      <= bit_q + 6'd1;
              if (bit_q == 6'd63) begin
                state_q    <= LATCH;
                seg_pen_q  <= 1'b1;
                seg_sout_q <= 1'b0;
              end
            end
          end
        end
        LATCH: begin
          div_q <= div_d;
          if (div_last) begin
            state_q   <= DONE;
            seg_pen_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign seg_clk  = seg_clk_q;
  assign seg_sout = seg_sout_q;
  assign SEG_PEN  = seg_pen_q;
  assign seg_clrn = seg_clrn_q;

endmodule
